// File: rtl/reg_file_sb_if.sv
// Register file bundle between the decode/control side and the register file.
// Latency: none of its own; it only groups the signals.
// Backpressure: none; hazard is the advisory stall back to the control unit.
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            init_done;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_used;
  logic            rs2_used;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            rd_wen;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            hazard;

  // Control-unit side.
  modport master (
    output rs1_addr, rs2_addr, rs1_used, rs2_used,
    output rd_addr, rd_data, rd_wen, issue_valid, issue_rd,
    input  init_done, rs1_data, rs2_data, rs1_busy, rs2_busy, hazard
  );

  // Register-file side.
  modport slave (
    input  rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  rd_addr, rd_data, rd_wen, issue_valid, issue_rd,
    output init_done, rs1_data, rs2_data, rs1_busy, rs2_busy, hazard
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with same-cycle write bypass, post-reset clear engine and busy scoreboard.
// Latency: reads 0 cycles (combinational); writes visible via bypass same cycle, via array next cycle.
// Backpressure: none taken; hazard is an advisory stall, issue updates happen regardless.
// Optional debug read port / busy mirror enabled by defining REGFILE_DBG_EN.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef REGFILE_DBG_EN
  input  logic [AW-1:0]        dbg_addr,
  output logic [XLEN-1:0]      dbg_data,
  output logic [(2**AW)-1:0]   dbg_busy,
`endif
  reg_file_sb_if.slave         bus
);
  localparam int            NREGS = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
  localparam logic [AW-1:0] R0    = '0;

  typedef enum logic {INIT, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs [NREGS];

  logic run;
  logic arr_wen;
  logic rd_hit1, rd_hit2, rd_hit_iss;
  logic z1, z2;

  assign run        = (state_q == RUN);
  assign arr_wen    = run && bus.rd_wen && !(ZERO_REG != 0 && bus.rd_addr == R0);
  assign rd_hit1    = bus.rd_wen && (bus.rd_addr == bus.rs1_addr);
  assign rd_hit2    = bus.rd_wen && (bus.rd_addr == bus.rs2_addr);
  assign rd_hit_iss = bus.rd_wen && (bus.rd_addr == bus.issue_rd);
  assign z1         = (ZERO_REG != 0) && (bus.rs1_addr == R0);
  assign z2         = (ZERO_REG != 0) && (bus.rs2_addr == R0);
  assign bus.init_done = run;

  // State, clear pointer and scoreboard registers; reset restarts the clear from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: INIT sweeps every entry once, the last entry's write moves to RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = RUN;
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Scoreboard update: retire clears, issue sets, so a new producer overrides a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (bus.rd_wen)      busy_d[bus.rd_addr]  = 1'b0;
      if (bus.issue_valid) busy_d[bus.issue_rd] = 1'b1;
      if (ZERO_REG != 0)   busy_d[0]            = 1'b0;
    end
  end

  // Storage array carries no reset; the clear engine zeroes it during INIT.
  always_ff @(posedge clk) begin
    if (!run)         regs[ptr_q]       <= '0;
    else if (arr_wen) regs[bus.rd_addr] <= bus.rd_data;
  end

  // Read ports: hardwired zero first, then same-cycle writeback bypass, then the array.
  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (run) begin
      if (z1)           bus.rs1_data = '0;
      else if (rd_hit1) bus.rs1_data = bus.rd_data;
      else              bus.rs1_data = regs[bus.rs1_addr];
      if (z2)           bus.rs2_data = '0;
      else if (rd_hit2) bus.rs2_data = bus.rd_data;
      else              bus.rs2_data = regs[bus.rs2_addr];
    end
  end

  // Hazard detection: a same-cycle writeback satisfies the pending producer.
  always_comb begin
    bus.rs1_busy = run && bus.rs1_used && busy_q[bus.rs1_addr] && !rd_hit1 && !z1;
    bus.rs2_busy = run && bus.rs2_used && busy_q[bus.rs2_addr] && !rd_hit2 && !z2;
    bus.hazard   = bus.rs1_busy || bus.rs2_busy ||
                   (run && bus.issue_valid && busy_q[bus.issue_rd] && !rd_hit_iss);
  end

`ifdef REGFILE_DBG_EN
  // Debug view: raw array contents (no bypass) and the busy vector.
  always_comb begin
    dbg_data = '0;
    if (run && !(ZERO_REG != 0 && dbg_addr == R0)) dbg_data = regs[dbg_addr];
    dbg_busy = busy_q;
  end
`endif
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam int S_INIT = 0, S_RS1 = 1, S_RS2 = 2, S_B1 = 3, S_B2 = 4, S_HAZ = 5;

  typedef struct {
    string       nm;
    int          sig;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  reg_file_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

`ifdef REGFILE_DBG_EN
  logic [AW-1:0]      dbg_addr;
  logic [XLEN-1:0]    dbg_data;
  logic [(2**AW)-1:0] dbg_busy;
`endif

  reg_file_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef REGFILE_DBG_EN
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .dbg_busy (dbg_busy),
`endif
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Monitor: at mid-cycle, pop every expectation raised for this cycle and compare.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.sig)
        S_INIT:  act = {31'd0, bus.init_done};
        S_RS1:   act = bus.rs1_data;
        S_RS2:   act = bus.rs2_data;
        S_B1:    act = {31'd0, bus.rs1_busy};
        S_B2:    act = {31'd0, bus.rs2_busy};
        default: act = {31'd0, bus.hazard};
      endcase
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: actual=0x%08h required=0x%08h", e.nm, e.cyc, act, e.val);
      end
    end
  end

  task automatic expect_sig(input string nm, input int sig, input logic [31:0] v);
    exp_t e;
    e.nm  = nm;
    e.sig = sig;
    e.val = v;
    e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.rs1_addr    = '0;
    bus.rs2_addr    = '0;
    bus.rs1_used    = 1'b0;
    bus.rs2_used    = 1'b0;
    bus.rd_addr     = '0;
    bus.rd_data     = '0;
    bus.rd_wen      = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
  endtask

  // Release reset and check the clear sweep: init_done low for 32 sampled cycles, then high.
  task automatic init_sweep(input string tag);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = AW'(i);
      bus.rs2_addr = AW'(31 - i);
      bus.rs1_used = 1'b1;
      expect_sig({tag, "_init_lo"}, S_INIT, 32'd0);
      if (i % 8 == 0) begin
        expect_sig({tag, "_rs1_zero"}, S_RS1, 32'd0);
        expect_sig({tag, "_rs2_zero"}, S_RS2, 32'd0);
        expect_sig({tag, "_haz_lo"}, S_HAZ, 32'd0);
      end
      step();
    end
    quiet();
    expect_sig({tag, "_init_hi"}, S_INIT, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef REGFILE_DBG_EN
    dbg_addr = '0;
`endif
    quiet();
    rst_n = 1'b0;
    step();
    expect_sig("rst_init_done", S_INIT, 32'd0);
    expect_sig("rst_hazard", S_HAZ, 32'd0);
    step();
    step();

    // 1: clear sweep after reset release.
    init_sweep("t1");
    bus.rs1_addr = 5'd13;
    bus.rs2_addr = 5'd31;
    expect_sig("t1_rs1_cleared", S_RS1, 32'd0);
    expect_sig("t1_rs2_cleared", S_RS2, 32'd0);
    step();

    // 2: write bypass same cycle, array read next cycle.
    bus.rd_wen = 1'b1; bus.rd_addr = 5'd5; bus.rd_data = 32'hDEADBEEF;
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
    expect_sig("t2_bypass", S_RS1, 32'hDEADBEEF);
    expect_sig("t2_other_port", S_RS2, 32'd0);
    step();
    bus.rd_wen = 1'b0; bus.rd_data = 32'h0;
    expect_sig("t2_array", S_RS1, 32'hDEADBEEF);
    bus.rs2_addr = 5'd5;
    expect_sig("t2_array_rs2", S_RS2, 32'hDEADBEEF);
    step();

    // 3: register 0 hardwired.
    quiet();
    bus.rd_wen = 1'b1; bus.rd_addr = 5'd0; bus.rd_data = 32'h1234; bus.rs2_addr = 5'd0;
    expect_sig("t3_r0_nobypass", S_RS2, 32'd0);
    step();
    quiet();
    expect_sig("t3_r0_array", S_RS2, 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    expect_sig("t3_r0_issue_haz", S_HAZ, 32'd0);
    step();
    quiet();
    bus.rs2_used = 1'b1; bus.rs2_addr = 5'd0;
    expect_sig("t3_r0_busy", S_B2, 32'd0);
    expect_sig("t3_r0_haz", S_HAZ, 32'd0);
    step();

    // 4: RAW hazard on 7 resolved by same-cycle writeback.
    quiet();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    expect_sig("t4a_issue_haz", S_HAZ, 32'd0);
    step();
    quiet();
    bus.rs1_addr = 5'd7; bus.rs1_used = 1'b1;
    expect_sig("t4b_rs1_busy", S_B1, 32'd1);
    expect_sig("t4b_hazard", S_HAZ, 32'd1);
    step();
    bus.rd_wen = 1'b1; bus.rd_addr = 5'd7; bus.rd_data = 32'h55;
    expect_sig("t4c_hazard", S_HAZ, 32'd0);
    expect_sig("t4c_rs1_busy", S_B1, 32'd0);
    expect_sig("t4c_rs1_data", S_RS1, 32'h55);
    step();
    bus.rd_wen = 1'b0; bus.rd_data = 32'h0;
    expect_sig("t4_busy7_clear", S_B1, 32'd0);
    expect_sig("t4_rs1_array", S_RS1, 32'h55);
    step();

    // 5: set beats clear on 9; a second issue is a WAW hazard.
    quiet();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    step();
    bus.rd_wen = 1'b1; bus.rd_addr = 5'd9; bus.rd_data = 32'h99;
    bus.rs1_addr = 5'd9; bus.rs1_used = 1'b1;
    expect_sig("t5_fwd_busy", S_B1, 32'd0);
    expect_sig("t5_fwd_haz", S_HAZ, 32'd0);
    step();
    quiet();
    bus.rs1_addr = 5'd9; bus.rs1_used = 1'b1;
    expect_sig("t5_busy9_kept", S_B1, 32'd1);
    expect_sig("t5_rs1_data", S_RS1, 32'h99);
    step();
    quiet();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    expect_sig("t5_waw", S_HAZ, 32'd1);
    step();
    quiet();
    bus.rd_wen = 1'b1; bus.rd_addr = 5'd9; bus.rd_data = 32'h100;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    expect_sig("t5_waw_fwd", S_HAZ, 32'd0);
    step();

    // 6: reset mid-RUN with busy[3] set, then reset again mid-INIT at ptr 10.
    quiet();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    step();
    quiet();
    bus.rs1_addr = 5'd3; bus.rs1_used = 1'b1;
    expect_sig("t6_busy3_set", S_B1, 32'd1);
    step();
    rst_n = 1'b0;
    expect_sig("t6_rst_init_done", S_INIT, 32'd0);
    expect_sig("t6_rst_busy", S_B1, 32'd0);
    step();
    rst_n = 1'b1;
    quiet();
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rd_wen = 1'b1; bus.rd_addr = 5'd4; bus.rd_data = 32'hAAAA;
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
      bus.rs1_addr = 5'd3; bus.rs1_used = 1'b1; bus.rs2_addr = 5'd4;
      expect_sig("t6_init_lo", S_INIT, 32'd0);
      if (i == 0 || i == 31) begin
        expect_sig("t6_init_rs2", S_RS2, 32'd0);
        expect_sig("t6_init_b1", S_B1, 32'd0);
        expect_sig("t6_init_haz", S_HAZ, 32'd0);
      end
      step();
    end
    quiet();
    expect_sig("t6_init_hi", S_INIT, 32'd1);
    bus.rs1_addr = 5'd3; bus.rs1_used = 1'b1;
    bus.rs2_addr = 5'd4;
    expect_sig("t6_busy3_cleared", S_B1, 32'd0);
    expect_sig("t6_r4_not_kept", S_RS2, 32'd0);
    step();
    quiet();
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd7;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    expect_sig("t6_r5_cleared", S_RS1, 32'd0);
    expect_sig("t6_r7_cleared", S_RS2, 32'd0);
    expect_sig("t6_busy9_cleared", S_HAZ, 32'd0);
    step();
    quiet();
    step();
    step();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: actual=%0d pending required=0 pending", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the core's 32x32 register file for the multicycle and pipelined cores.
- Generalised in data width and register count.
- Same-cycle write-to-read bypass on both read ports.
- Sequential post-reset clear engine, so the storage array needs no per-entry reset.
- Per-register busy scoreboard, so the control unit can stall on RAW/WAW hazards against in-flight multicycle results.

Parameters:
XLEN, 32, data width of every register and data port
AW, 5, register address width; NREGS = 2**AW registers
ZERO_REG, 1, 1 = register 0 hardwired to zero (reads 0, writes and issues to it ignored); 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
init_done  output  1  high once the clear engine has finished; all write/issue inputs ignored while low
rs1_addr  input  AW  read port 1 address
rs2_addr  input  AW  read port 2 address
rs1_data  output  XLEN  read port 1 data, combinational
rs2_data  output  XLEN  read port 2 data, combinational
rs1_used  input  1  instruction in decode reads rs1
rs2_used  input  1  instruction in decode reads rs2
rd_addr  input  AW  writeback address
rd_data  input  XLEN  writeback data
rd_wen  input  1  writeback enable; also clears busy[rd_addr]
issue_valid  input  1  an instruction with a destination is issued this cycle; sets busy[issue_rd]
issue_rd  input  AW  destination of the issued instruction
rs1_busy  output  1  rs1 has a pending producer not satisfied this cycle
rs2_busy  output  1  rs2 has a pending producer not satisfied this cycle
hazard  output  1  stall request to control unit

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM enters INIT; clear pointer = 0; busy[] = all 0; init_done = 0.
  - Storage array is not reset directly.
  - Reset mid-operation, including mid-INIT, restarts the clear from pointer 0.
- FSM states INIT and RUN:
  - INIT: each cycle writes 0 to regs[ptr], then ptr increments.
  - INIT to RUN on the cycle that writes ptr == NREGS-1, so INIT lasts exactly NREGS cycles after rst_n deasserts.
  - RUN is terminal until the next reset.
  - init_done is registered and equals (state == RUN).
- During INIT:
  - rs1_data and rs2_data read 0; rs1_busy, rs2_busy and hazard are 0.
  - rd_wen and issue_valid are ignored: no array write, no busy change.
- Read, in RUN, for each port x:
  - If ZERO_REG and rsx_addr == 0: data = 0.
  - Else if rd_wen and rd_addr == rsx_addr: data = rd_data (bypass, same cycle).
  - Else: data = regs[rsx_addr].
- Write, in RUN: on the clock edge with rd_wen, regs[rd_addr] <= rd_data, unless ZERO_REG and rd_addr == 0.
- Scoreboard, in RUN:
  - busy[issue_rd] set on issue_valid.
  - busy[rd_addr] cleared on rd_wen.
  - Set and clear on the same address in the same cycle: set wins, because a new producer supersedes the retiring one.
  - With ZERO_REG, busy[0] stays 0.
- Busy outputs:
  - rsx_busy = rsx_used & busy[rsx_addr] & !(rd_wen & rd_addr == rsx_addr), because writeback in the same cycle is forwarded.
  - rsx_busy is forced to 0 for address 0 when ZERO_REG.
- Hazard:
  - waw = issue_valid & busy[issue_rd] & !(rd_wen & rd_addr == issue_rd).
  - hazard = rs1_busy | rs2_busy | waw.
  - hazard is advisory; the block still performs the issue update if issue_valid is asserted. The control unit must gate issue_valid with !hazard.
- Latency:
  - Reads are combinational, 0 cycles.
  - Write is visible through the array on the next cycle, and through the bypass in the same cycle.

Optional Feature:
Macro REGFILE_DBG_EN.
- Defined: adds ports dbg_addr (input, AW) and dbg_data (output, XLEN), plus dbg_busy (output, 2**AW), a mirror of busy[].
  - dbg_data = regs[dbg_addr], no bypass.
  - dbg_data = 0 for address 0 when ZERO_REG, and 0 during INIT.
- Not defined: those ports do not exist. Functional behaviour is otherwise identical.

Test Plan:
1. Release rst_n, defaults -> init_done is 0 for exactly 32 cycles, then 1; every rsx_data reads 0.
2. RUN, rd_wen=1, rd_addr=5, rd_data=0xDEADBEEF, rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF same cycle; next cycle, with rd_wen=0, rs1_data=0xDEADBEEF.
3. Write rd_addr=0, rd_data=0x1234 with ZERO_REG=1 -> rs2_addr=0 reads 0; issue_rd=0 then rs2_used=1 -> rs2_busy=0.
4. Scoreboard:
   - Step a: issue_valid with issue_rd=7.
   - Step b: next cycle rs1_addr=7, rs1_used=1 -> hazard=1.
   - Step c: rd_wen with rd_addr=7 and rd_data=0x55 -> same cycle hazard=0, rs1_data=0x55; busy[7]=0 afterwards.
5. Same cycle issue_rd=9 and rd_wen with rd_addr=9 while busy[9]=1 -> busy[9] remains 1; a second issue to 9 -> waw hazard=1.
6. Assert rst_n low mid-INIT at ptr=10, then with busy[3] set in RUN -> init restarts, 32 more cycles to init_done; busy[] all 0; writes during INIT are not retained.
